aether_mem_task_master: RTL

Initiator for the Aether engine's task-based memory port. Accepts a transfer request (read or write over an inclusive address range) from engine logic, issues the single-cycle task command with its address range, streams write words in through a valid/ready port and read words out through a FIFO-backed valid/ready port, and reports completion, errors and timeouts. Sits between the compute pipeline and the memory block, so upstream logic never handles task-level sequencing.

---
 rtl/aether_mem_task_master.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aether_mem_task_master.sv
// aether_mem_task_master: task-based memory port initiator.
// Accepts a read/write range request, issues a one-cycle task command,
// streams write words to memory and buffers read words in a FWFT FIFO.
module aether_mem_task_master #(
  parameter int unsigned DataWidth     = 16,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned ReadFifoDepth = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_start_i,
  input  logic [AddrWidth-1:0] req_end_i,
  // write stream
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  // read stream
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  // status
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  // memory side
  output logic [1:0]           mem_command_o,
  output logic [AddrWidth-1:0] mem_start_address_o,
  output logic [AddrWidth-1:0] mem_end_address_o,
  output logic [DataWidth-1:0] mem_data_write_o,
  output logic                 mem_en_o,
  input  logic [DataWidth-1:0] mem_data_read_i,
  input  logic                 mem_data_read_valid_i,
  input  logic                 mem_data_write_ready_i,
  input  logic                 mem_task_finished_i,
  input  logic                 mem_running_i
);

  localparam int unsigned LenW = AddrWidth + 1;
  localparam int unsigned PtrW = $clog2(ReadFifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  localparam logic [1:0] CmdIdle  = 2'b00;
  localparam logic [1:0] CmdWrite = 2'b01;
  localparam logic [1:0] CmdRead  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  state_e               r_state;
  state_e               w_state_next;

  logic                 r_write;
  logic [AddrWidth-1:0] r_start;
  logic [AddrWidth-1:0] r_end;
  logic [LenW-1:0]      r_len;
  logic [LenW-1:0]      r_count;
  logic                 r_fin_seen;
  logic [TmoW-1:0]      r_tmo;
  logic                 r_error;

  logic [DataWidth-1:0] r_fifo_mem [ReadFifoDepth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_fifo_cnt;

  logic [LenW-1:0]      w_len;
  logic                 w_reject;
  logic [CntW-1:0]      w_fifo_free;
  logic                 w_wait_space;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_go;
  logic                 w_has_room;
  logic                 w_wr_fire;
  logic                 w_rd_word;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_overflow;
  logic                 w_word;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_abort;
  logic                 w_unused_running;

  // memory running status carries no sequencing information here
  assign w_unused_running = mem_running_i;

  // request decode: length, rejection and FIFO space back-pressure
  always_comb begin
    w_len        = LenW'(req_end_i) - LenW'(req_start_i) + LenW'(1);
    w_reject     = (req_end_i < req_start_i) || (req_end_i == '0) ||
                   (!req_write_i && (w_len > LenW'(ReadFifoDepth)));
    w_fifo_free  = CntW'(ReadFifoDepth) - r_fifo_cnt;
    w_wait_space = !req_write_i && !w_reject && (w_len > LenW'(w_fifo_free));
    w_req_ready  = (r_state == ST_IDLE) && !(req_valid_i && w_wait_space);
    w_accept     = req_valid_i && w_req_ready;
    w_go         = w_accept && !w_reject;
  end

  // transfer datapath strobes
  always_comb begin
    w_has_room = r_count < r_len;
    w_wr_fire  = (r_state == ST_XFER) && r_write && wr_valid_i &&
                 mem_data_write_ready_i && w_has_room;
    w_rd_word  = (r_state == ST_XFER) && !r_write && mem_data_read_valid_i;
    w_push     = w_rd_word && w_has_room;
    w_overflow = w_rd_word && !w_has_room;
    w_pop      = (r_fifo_cnt != '0) && rd_ready_i;
    w_word     = w_wr_fire || w_push;
    w_complete = (r_count == r_len) && (r_fin_seen || mem_task_finished_i);
    w_timeout  = !w_word && (r_tmo == TmoW'(TimeoutCycles - 1));
    w_abort    = (r_state == ST_XFER) && !w_complete && w_timeout;
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state and state-derived outputs
  always_comb begin
    w_state_next  = r_state;
    mem_command_o = CmdIdle;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (w_go) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_command_o = r_write ? CmdWrite : CmdRead;
        w_state_next  = ST_XFER;
      end
      ST_XFER: begin
        if (w_complete) begin
          w_state_next = ST_FINISH;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FINISH: begin
        done_o       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // task context captured at accept; progress counters during the transfer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_write    <= 1'b0;
      r_start    <= '0;
      r_end      <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_fin_seen <= 1'b0;
      r_tmo      <= '0;
    end else if (w_go) begin
      r_write    <= req_write_i;
      r_start    <= req_start_i;
      r_end      <= req_end_i;
      r_len      <= w_len;
      r_count    <= '0;
      r_fin_seen <= 1'b0;
      r_tmo      <= '0;
    end else begin
      if (w_word) begin
        r_count <= r_count + LenW'(1);
      end
      if ((r_state == ST_ISSUE || r_state == ST_XFER) && mem_task_finished_i) begin
        r_fin_seen <= 1'b1;
      end
      if (r_state == ST_XFER) begin
        r_tmo <= w_word ? '0 : r_tmo + TmoW'(1);
      end
    end
  end

  // sticky error: set by rejection, surplus read words or timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= w_reject;
    end else if (w_overflow || w_abort) begin
      r_error <= 1'b1;
    end
  end

  // read FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CntW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CntW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // read FIFO storage
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= mem_data_read_i;
    end
  end

  assign req_ready_o         = w_req_ready;
  assign error_o             = r_error;
  assign mem_start_address_o = r_start;
  assign mem_end_address_o   = r_end;
  assign wr_ready_o          = w_wr_fire;
  assign mem_en_o            = w_wr_fire;
  assign mem_data_write_o    = w_wr_fire ? wr_data_i : '0;
  assign rd_valid_o          = (r_fifo_cnt != '0);
  assign rd_data_o           = rd_valid_o ? r_fifo_mem[r_rd_ptr] : '0;

endmodule
